// File: rtl/rm14_pkg.sv
// Shared RM(1,4) definitions: widths, systematic encoder and 11-bit parity-check syndrome.
// Encoder and decoder both use these functions.
package rm14_pkg;

    localparam int MSG_W = 5;
    localparam int CW_W  = 16;
    localparam int SYN_W = 11;

    function automatic logic [CW_W-1:0] rm14_encode(input logic [MSG_W-1:0] m);
        logic [CW_W-1:0] c;
        c[4:0] = m;
        c[5]   = m[0] ^ m[1] ^ m[2];
        c[6]   = m[0] ^ m[1] ^ m[3];
        c[7]   = m[0] ^ m[1] ^ m[4];
        c[8]   = m[0] ^ m[2] ^ m[3];
        c[9]   = m[0] ^ m[2] ^ m[4];
        c[10]  = m[0] ^ m[3] ^ m[4];
        c[11]  = m[1] ^ m[2] ^ m[3];
        c[12]  = m[1] ^ m[2] ^ m[4];
        c[13]  = m[1] ^ m[3] ^ m[4];
        c[14]  = m[2] ^ m[3] ^ m[4];
        c[15]  = ^m;
        return c;
    endfunction

    // Each syndrome bit is one parity equation: received parity vs. parity recomputed from cw[4:0].
    function automatic logic [SYN_W-1:0] rm14_syndrome(input logic [CW_W-1:0] c);
        logic [CW_W-1:0] r;
        r = rm14_encode(c[MSG_W-1:0]);
        return c[CW_W-1:MSG_W] ^ r[CW_W-1:MSG_W];
    endfunction

endpackage

// File: rtl/rm14_msg_fifo.sv
// Show-ahead message FIFO, DEPTH entries (power of two); head visible on o_dat with zero latency.
// Pushes are ignored when full, pops are ignored when empty; push and pop may coincide.
module rm14_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/rm14_encoder.sv
// RM(1,4) systematic encoder: 5-bit msg -> 16-bit cw through input FIFO and one output register.
// Latency 1 cycle after acceptance; msg_ready = FIFO not full; cw held stable while !cw_ready.
// Optional single-bit error injector enabled by defining RM14_ERR_INJECT_EN.
module rm14_encoder
    import rm14_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16,
    parameter int ERR_PERIOD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       msg,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [15:0]      cw,
    output logic             cw_valid,
    input  logic             cw_ready,
    output logic [CNT_W-1:0] cw_count,
    output logic [15:0]      err_mask
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ERR_PERIOD < 1) begin : g_bad_params
        $error("rm14_encoder: DEPTH must be a power of two >= 2 and ERR_PERIOD >= 1");
    end

    logic [MSG_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_load;
    logic [CW_W-1:0]  w_mask;
    logic [CW_W-1:0]  r_cw;
    logic             r_cw_valid;
    logic [CNT_W-1:0] r_cw_count;

    assign msg_ready = !w_full;
    assign w_load    = !w_empty && (!r_cw_valid || cw_ready);

    rm14_msg_fifo #(
        .DEPTH (DEPTH),
        .W     (MSG_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (msg_valid),
        .i_dat   (msg),
        .i_pop   (w_load),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef RM14_ERR_INJECT_EN
    localparam int PW = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;

    logic [PW-1:0]   r_period;
    logic [3:0]      r_pos;
    logic [CW_W-1:0] r_err_mask;
    logic            w_inject;

    assign w_inject = (r_period == PW'(ERR_PERIOD - 1));
    assign w_mask   = w_inject ? (16'd1 << r_pos) : '0;
    assign err_mask = r_err_mask;

    // Counters advance only on output loads so the pattern follows codewords, not cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period   <= '0;
            r_pos      <= '0;
            r_err_mask <= '0;
        end else if (w_load) begin
            r_err_mask <= w_mask;
            if (w_inject) begin
                r_period <= '0;
                r_pos    <= r_pos + 1'b1;
            end else begin
                r_period <= r_period + 1'b1;
            end
        end
    end
`else
    assign w_mask   = '0;
    assign err_mask = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cw       <= '0;
            r_cw_valid <= 1'b0;
            r_cw_count <= '0;
        end else begin
            if (w_load) begin
                r_cw       <= rm14_encode(w_head) ^ w_mask;
                r_cw_valid <= 1'b1;
            end else if (cw_ready) begin
                r_cw_valid <= 1'b0;
            end
            if (r_cw_valid && cw_ready) begin
                r_cw_count <= r_cw_count + 1'b1;
            end
        end
    end

    assign cw       = r_cw;
    assign cw_valid = r_cw_valid;
    assign cw_count = r_cw_count;

endmodule

// File: tb/tb_rm14_encoder.sv
// Self-checking bench for rm14_encoder: expected codewords queued at push, compared at each cw handshake.
module tb_rm14_encoder;
    import rm14_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int ERR_P = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       msg;
    logic             msg_valid;
    logic             msg_ready;
    logic [15:0]      cw;
    logic             cw_valid;
    logic             cw_ready;
    logic [CNT_W-1:0] cw_count;
    logic [15:0]      err_mask;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          n_deliv  = 0;
    int          n_inj    = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_cw;
    logic [15:0] prev_mask;

    rm14_encoder #(
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .ERR_PERIOD (ERR_P)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .msg       (msg),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .cw        (cw),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw_count  (cw_count),
        .err_mask  (err_mask)
    );

    always #5 clk = ~clk;

    // Monitor: handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        logic [15:0] e;
        logic [15:0] exp_mask;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!cw_valid || cw !== prev_cw || err_mask !== prev_mask) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b cw=%h mask=%h, required valid=1 cw=%h mask=%h",
                             cw_valid, cw, err_mask, prev_cw, prev_mask);
                end
            end
            if (cw_valid && cw_ready) begin
                n_deliv++;
                exp_mask = '0;
`ifdef RM14_ERR_INJECT_EN
                if (n_deliv % ERR_P == 0) exp_mask = 16'd1 << ((n_deliv / ERR_P - 1) % 16);
`endif
                if (err_mask != 0) n_inj++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_unexpected: cw=%h delivered with no expected entry", cw);
                end else begin
                    e = exp_q.pop_front();
                    if ((cw ^ err_mask) !== e || err_mask !== exp_mask) begin
                        n_fail++;
                        $display("FAIL scoreboard #%0d: cw=%h mask=%h, required clean=%h mask=%h",
                                 n_deliv, cw, err_mask, e, exp_mask);
                    end
                end
            end
            prev_stall = cw_valid && !cw_ready;
            prev_cw    = cw;
            prev_mask  = err_mask;
        end
    end

    task automatic drive(input logic [4:0] m);
        int t = 0;
        msg       = m;
        msg_valid = 1'b1;
        @(negedge clk);
        while (!msg_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!msg_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_timeout: msg_ready=0 for 50 cycles, required 1");
        end else begin
            exp_q.push_back(rm14_encode(m));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || cw_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0 || cw_valid) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d pending, cw_valid=%b, required 0 and 0", exp_q.size(), cw_valid);
        end
        n_checks++;
        if (cw_count !== CNT_W'(n_deliv)) begin
            n_fail++;
            $display("FAIL cw_count: got %0d, required %0d", cw_count, n_deliv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        n_deliv = 0;
        n_inj   = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        msg       = '0;
        msg_valid = 1'b0;
        cw_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cw_valid !== 1'b0 || msg_ready !== 1'b1 || cw !== 16'h0 || cw_count !== '0 || err_mask !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b cw=%h count=%0d mask=%h, required 0 1 0000 0 0000",
                     cw_valid, msg_ready, cw, cw_count, err_mask);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        cw_ready = 1'b1;
        drive(5'b00001);
        msg_valid = 1'b0;
        n_checks++;
        if (cw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_bypass: cw_valid=%b right after accept, required 0", cw_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cw_valid !== 1'b1 || cw !== 16'h87E1) begin
            n_fail++;
            $display("FAIL single_latency: valid=%b cw=%h, required 1 87e1", cw_valid, cw);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cw_count !== 16'd1 || cw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count: count=%0d valid=%b, required 1 0", cw_count, cw_valid);
        end
    endtask

    task automatic test_back_to_back();
        cw_ready = 1'b1;
        drive(5'h00);
        drive(5'h1F);
        drive(5'h03);
        msg_valid = 1'b0;
        n_checks++;
        if (cw_valid !== 1'b1 || cw !== 16'hFFFF || rm14_syndrome(cw) !== '0) begin
            n_fail++;
            $display("FAIL stream_second: valid=%b cw=%h syn=%h, required 1 ffff 000", cw_valid, cw, rm14_syndrome(cw));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cw_valid !== 1'b1 || cw !== 16'h3F03 || rm14_syndrome(cw) !== '0) begin
            n_fail++;
            $display("FAIL stream_third: valid=%b cw=%h syn=%h, required 1 3f03 000", cw_valid, cw, rm14_syndrome(cw));
        end
        drain();
    endtask

    task automatic test_stall();
        logic [4:0] vals[5] = '{5'h05, 5'h0A, 5'h11, 5'h16, 5'h1B};
        cw_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(vals[i]);
        msg_valid = 1'b0;
        n_checks++;
        if (msg_ready !== 1'b0 || cw_valid !== 1'b1 || cw !== rm14_encode(vals[0])) begin
            n_fail++;
            $display("FAIL stall_full: ready=%b valid=%b cw=%h, required 0 1 %h",
                     msg_ready, cw_valid, cw, rm14_encode(vals[0]));
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (msg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: msg_ready=%b while full, required 0", msg_ready);
        end
        cw_ready = 1'b1;
        drain();
    endtask

    task automatic test_fifo_wrap();
        cw_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive(5'(i + 7));
        cw_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (msg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_ready cycle %0d: msg_ready=%b, required 1", i, msg_ready);
            end
            drive(5'($urandom_range(0, 31)));
        end
        cw_ready  = 1'b0;
        msg_valid = 1'b0;
        @(posedge clk);
        #1;
        drive(5'h15);
        msg_valid = 1'b0;
        n_checks++;
        if (msg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_occupancy: msg_ready=%b after one extra push, required 0", msg_ready);
        end
        cw_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        cw_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(5'(i + 20));
        msg_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        n_deliv = 0;
        n_inj   = 0;
        #1;
        n_checks++;
        if (cw_valid !== 1'b0 || msg_ready !== 1'b1 || cw_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b ready=%b count=%0d, required 0 1 0", cw_valid, msg_ready, cw_count);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cw_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cw_valid) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_stale: cw_valid=1 after reset with nothing pushed, required 0");
        end
    endtask

    task automatic test_inject();
        int exp_inj;
        do_reset();
        cw_ready = 1'b1;
        for (int i = 0; i < 32; i++) drive(5'($urandom_range(0, 31)));
        msg_valid = 1'b0;
        drain();
`ifdef RM14_ERR_INJECT_EN
        exp_inj = 32 / ERR_P;
`else
        exp_inj = 0;
`endif
        n_checks++;
        if (n_inj != exp_inj) begin
            n_fail++;
            $display("FAIL inject_count: %0d corrupted codewords, required %0d", n_inj, exp_inj);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_fifo_wrap();
        test_reset_mid();
        test_inject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rm14_encoder.md
Name: rm14_encoder

Overview:
- Upstream stage of the RM(1,4) decoder: takes 5-bit messages over a valid/ready handshake, buffers them, and produces systematic 16-bit codewords.
- Each codeword has zero syndrome under the decoder's 11 parity checks.
- Output feeds the channel/decoder `r` input.
- Includes an input FIFO, a registered output stage, and a codeword counter; an optional error injector exercises the decoder.

Parameters:
- DEPTH, 4, input FIFO entries (power of two, ≥2)
- CNT_W, 16, width of codeword counter
- ERR_PERIOD, 8, inject one error every ERR_PERIOD codewords (only with RM14_ERR_INJECT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- msg  in  5  message bits m[4:0]
- msg_valid  in  1  msg present
- msg_ready  out  1  FIFO can accept (not full)
- cw  out  16  codeword (possibly corrupted when injection enabled)
- cw_valid  out  1  cw holds a codeword
- cw_ready  in  1  downstream accepts cw
- cw_count  out  CNT_W  codewords delivered (handshakes completed)
- err_mask  out  16  bits flipped in current cw (zero when injection compiled out)

Behaviour:
- Reset (async, immediate):
  - FIFO empty; msg_ready=1; cw_valid=0; cw=0; cw_count=0; err_mask=0; injector counter=0.
- Encoding (systematic, bit index = codeword position):
  - cw[4:0]=m[4:0]
  - cw5=m0^m1^m2, cw6=m0^m1^m3, cw7=m0^m1^m4, cw8=m0^m2^m3, cw9=m0^m2^m4, cw10=m0^m3^m4
  - cw11=m1^m2^m3, cw12=m1^m2^m4, cw13=m1^m3^m4, cw14=m2^m3^m4
  - cw15=m0^m1^m2^m3^m4
- Input handshake:
  - A push occurs when msg_valid && msg_ready at the clock edge.
  - msg_ready = !full, registered-equivalent: it depends only on state, never on msg_valid.
- FIFO: show-ahead, DEPTH entries, pointer wrap modulo DEPTH, separate occupancy count 0..DEPTH.
- Output stage is a single register:
  - Load condition: FIFO non-empty && (!cw_valid || cw_ready).
  - On load: pop head, cw←encode(head)^mask, cw_valid←1.
  - When cw_valid && cw_ready and the FIFO is empty: cw_valid←0, cw holds its last value.
- Latency and throughput:
  - Message accepted at edge N into an empty block with an idle output → cw_valid=1 after edge N+1.
  - Throughput is one codeword per cycle with cw_ready held high.
- Handshake hold rules:
  - While cw_valid && !cw_ready, cw and err_mask stay stable.
  - cw_valid never drops without a handshake.
- Simultaneous push and pop:
  - Occupancy unchanged.
  - Allowed at any level below full. When full, msg_ready=0, so no push occurs that cycle even if a pop happens.
- cw_count increments on each cw_valid && cw_ready and wraps at 2^CNT_W.
- No bypass path: the FIFO is always traversed, giving a fixed latency of 1 cycle.
- Reset mid-operation: all buffered messages are discarded; the in-flight cw is dropped (cw_valid=0 immediately).

Optional Feature:
- Macro RM14_ERR_INJECT_EN.
- With the macro defined:
  - A 4-bit position counter p and a period counter advance on every output load.
  - On every ERR_PERIOD-th load (period counter wraps to 0), err_mask = 1<<p, cw bit p is flipped, and p increments mod 16.
  - On all other loads, err_mask=0.
  - A single-bit error is always within the decoder's correction capability.
- Without the macro: no injector logic; err_mask tied to 0; cw is exactly encode(msg).

Decomposition:
- Package rm14_pkg: MSG_W=5, CW_W=16, SYN_W=11, parity-equation function rm14_encode(msg) → 16 bits, and function rm14_syndrome(cw) → 11 bits.
  - The bench and the decoder share these, so encoder/decoder consistency is checked from one source.
- One natural sub-module: rm14_msg_fifo (parameterised show-ahead FIFO with full/empty/count). Encoder, output register and injector stay in the top.

Test Plan:
- Reset then single msg 5'b00001 with cw_ready=1 → cw=16'h87E1 with cw_valid high one cycle after acceptance; cw_count=1 after the handshake.
- Stream msg 0x00, 0x1F, 0x03 back-to-back with cw_ready=1 → cw sequence 16'h0000, 16'hFFFF, 16'h3F03 on consecutive cycles; rm14_syndrome of each =0.
- Hold cw_ready=0, push 5 messages with DEPTH=4:
  - Output register takes 1, FIFO takes 4, msg_ready=0 thereafter.
  - Release cw_ready → all 5 delivered in order, cw stable while stalled.
- FIFO at DEPTH-1 with simultaneous push and pop each cycle for 20 cycles → occupancy constant, no drop or duplicate, pointers wrap correctly.
- Assert rst for one cycle while 3 entries are buffered and cw_valid=1 → cw_valid=0 and msg_ready=1 immediately, cw_count=0, and no stale codeword emerges afterwards.
- With RM14_ERR_INJECT_EN, ERR_PERIOD=8, 32 messages → err_mask nonzero on codewords 8, 16, 24, 32 (bits 0, 1, 2, 3); cw^err_mask equals clean encode for all 32.
